// File: rtl/rec_tq_pkg.sv
// Shared definitions for the rec_tq transform path: size and colour
// encodings, scheduler states, beats-per-block lookup and re latencies.
package rec_tq_pkg;

  localparam logic [1:0] TS_4  = 2'b00;
  localparam logic [1:0] TS_8  = 2'b01;
  localparam logic [1:0] TS_16 = 2'b10;
  localparam logic [1:0] TS_32 = 2'b11;

  localparam logic [1:0] TQ_LUMA     = 2'b00;
  localparam logic [1:0] TQ_LUMA_ALT = 2'b01;
  localparam logic [1:0] TQ_CB       = 2'b10;
  localparam logic [1:0] TQ_CR       = 2'b11;

  localparam int LAT_BIG   = 3;
  localparam int LAT_SMALL = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // Index of the last 32-coefficient beat of a block of the given size.
  function automatic logic [4:0] beats_last(input logic [1:0] ts);
    case (ts)
      TS_4:    return 5'd0;
      TS_8:    return 5'd1;
      TS_16:   return 5'd7;
      default: return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/re_row_sched_if.sv
// Command, source-beat and re-side signals of the row scheduler.
// The slave modport is the scheduler itself; master is its environment.
interface re_row_sched_if;
  logic       blk_start;
  logic       blk_inverse;
  logic [1:0] blk_tq_sel;
  logic [1:0] blk_transize;
  logic       blk_ready;
  logic       src_vld;
  logic       src_rdy;
  logic       re_dt_vld;
  logic       re_inverse;
  logic [1:0] re_tq_sel;
  logic [1:0] re_transize;
  logic       re_o_vld;
  logic       credit_ret;
  logic [4:0] beat_idx;
  logic       blk_done;
  logic       busy;
  logic       err;

  modport slave (
    input  blk_start, blk_inverse, blk_tq_sel, blk_transize,
    input  src_vld, re_o_vld, credit_ret,
    output blk_ready, src_rdy, re_dt_vld, re_inverse, re_tq_sel, re_transize,
    output beat_idx, blk_done, busy, err
  );

  modport master (
    output blk_start, blk_inverse, blk_tq_sel, blk_transize,
    output src_vld, re_o_vld, credit_ret,
    input  blk_ready, src_rdy, re_dt_vld, re_inverse, re_tq_sel, re_transize,
    input  beat_idx, blk_done, busy, err
  );
endinterface

// File: rtl/re_row_sched_credit_cnt.sv
// Saturating up/down counter. Simultaneous inc and dec cancel; an inc at
// MAX or a dec at zero is dropped and flagged for the caller.
module re_credit_cnt #(
  parameter int W    = 4,
  parameter int MAX  = 15,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf,
  output logic         unf
);

  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  assign ovf = inc & ~dec & (cnt == MAX_V);
  assign unf = dec & ~inc & (cnt == '0);

  // Count register: step once per unmatched inc/dec, hold at the limits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= INIT_V;
    end else if (inc && !dec && cnt != MAX_V) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/re_row_sched.sv
// Beat scheduler for the re partial-butterfly stage: takes one block
// command at a time, pops source beats under downstream credit control,
// counts re outputs and pulses blk_done when a block has fully left re.
module re_row_sched
  import rec_tq_pkg::*;
#(
  parameter int CREDIT = 4,
  parameter int CW     = 4
) (
  input logic           clk,
  input logic           rst,
  re_row_sched_if.slave bus
);

  sched_state_t state, state_nxt;

  logic [CW-1:0] credits, inflight;
  logic          credit_ovf, credit_unf, inflight_ovf, inflight_unf;
  logic [4:0]    beat_idx_q, out_cnt, last_idx;
  logic          inv_q;
  logic [1:0]    tq_q, ts_q;
  logic          done_q, err_q;
  logic          src_rdy_c, blk_ready_c;
  logic          fire, accept, cfg_match, out_evt;

  assign last_idx  = beats_last(ts_q);
  assign fire      = bus.src_vld & src_rdy_c;
  assign accept    = bus.blk_start & blk_ready_c;
  assign cfg_match = (bus.blk_inverse == inv_q) && (bus.blk_tq_sel == tq_q) &&
                     (bus.blk_transize == ts_q);
  assign out_evt   = bus.re_o_vld & ~inflight_unf;

  re_credit_cnt #(.W(CW), .MAX(CREDIT), .INIT(CREDIT)) u_credits (
    .clk (clk),
    .rst (rst),
    .inc (bus.credit_ret),
    .dec (fire),
    .cnt (credits),
    .ovf (credit_ovf),
    .unf (credit_unf)
  );

  re_credit_cnt #(.W(CW), .MAX((1 << CW) - 1), .INIT(0)) u_inflight (
    .clk (clk),
    .rst (rst),
    .inc (fire),
    .dec (bus.re_o_vld),
    .cnt (inflight),
    .ovf (inflight_ovf),
    .unf (inflight_unf)
  );

  // Next state plus the two handshake readies; DRAIN only takes a command
  // that matches the held config, so overlapping blocks never change it.
  always_comb begin
    state_nxt   = state;
    src_rdy_c   = 1'b0;
    blk_ready_c = 1'b0;
    case (state)
      IDLE: begin
        blk_ready_c = 1'b1;
        if (bus.blk_start) state_nxt = RUN;
      end
      RUN: begin
        src_rdy_c = (credits != '0);
        if (fire && beat_idx_q == last_idx) state_nxt = DRAIN;
      end
      DRAIN: begin
        blk_ready_c = cfg_match;
        if (accept) state_nxt = RUN;
        else if (inflight == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // re config is latched only when a command is taken in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= 1'b0;
      tq_q  <= 2'b00;
      ts_q  <= 2'b00;
    end else if (state == IDLE && accept) begin
      inv_q <= bus.blk_inverse;
      tq_q  <= bus.blk_tq_sel;
      ts_q  <= bus.blk_transize;
    end
  end

  // Issue-side beat index: wraps to zero after the last beat of a block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx_q <= 5'd0;
    end else if (state == IDLE && accept) begin
      beat_idx_q <= 5'd0;
    end else if (fire) begin
      beat_idx_q <= (beat_idx_q == last_idx) ? 5'd0 : beat_idx_q + 5'd1;
    end
  end

  // Output-side beat count; completing a block raises blk_done next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= out_evt && (out_cnt == last_idx);
      if (out_evt) out_cnt <= (out_cnt == last_idx) ? 5'd0 : out_cnt + 5'd1;
    end
  end

  // Sticky error on stray re outputs or credits returned beyond the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | credit_ovf | credit_unf | inflight_ovf | inflight_unf;
  end

  assign bus.blk_ready   = blk_ready_c;
  assign bus.src_rdy     = src_rdy_c;
  assign bus.re_dt_vld   = fire;
  assign bus.re_inverse  = inv_q;
  assign bus.re_tq_sel   = tq_q;
  assign bus.re_transize = ts_q;
  assign bus.beat_idx    = beat_idx_q;
  assign bus.blk_done    = done_q;
  assign bus.busy        = (state != IDLE);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_re_row_sched.sv
// Scoreboard bench for re_row_sched: commands push expected beats, a
// behavioural re/downstream model answers fires, a monitor checks them.
module tb_re_row_sched;
  import rec_tq_pkg::*;

  typedef struct {
    logic [4:0] idx;
    logic       inv;
    logic [1:0] tq;
    logic [1:0] ts;
    int         lat;
    bit         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  re_row_sched_if bus ();

  re_row_sched #(.CREDIT(4), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   epoch = 0;
  int   fire_cnt = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];
  bit   last_q[$];
  int   done_q[$];
  int   fire_cyc[$];
  int   o_due[256];
  int   o_ep[256];
  int   cr_due[256];
  int   cr_ep[256];
  bit   model_o_now = 1'b0;
  bit   credit_echo = 1'b0;
  bit   inj_o = 1'b0;
  bit   inj_credit = 1'b0;

  // Cycle counter used to timestamp fires, outputs and blk_done.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural re and downstream buffer: drive scheduled outputs/credits.
  initial begin
    bus.re_o_vld   = 1'b0;
    bus.credit_ret = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      model_o_now    = (o_due[cyc % 256] == cyc) && (o_ep[cyc % 256] == epoch);
      bus.re_o_vld   = model_o_now | inj_o;
      bus.credit_ret = ((cr_due[cyc % 256] == cyc) && (cr_ep[cyc % 256] == epoch)) | inj_credit;
    end
  end

  // Monitor: compare each issued beat, schedule re responses, time blk_done.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   l;
    if (!rst) begin
      if (bus.re_dt_vld) begin
        fire_cnt++;
        fire_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checkOutput("issue_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("issue", {bus.beat_idx, bus.re_inverse, bus.re_tq_sel, bus.re_transize},
                      {e.idx, e.inv, e.tq, e.ts});
          o_due[(cyc + e.lat) % 256] = cyc + e.lat;
          o_ep[(cyc + e.lat) % 256]  = epoch;
          last_q.push_back(e.last);
        end
      end
      if (model_o_now) begin
        if (last_q.size() > 0) begin
          l = last_q.pop_front();
          if (l) done_q.push_back(cyc + 1);
        end
        if (credit_echo) begin
          cr_due[(cyc + 4) % 256] = cyc + 4;
          cr_ep[(cyc + 4) % 256]  = epoch;
        end
      end
      if (bus.blk_done) begin
        done_cnt++;
        if (done_q.size() == 0) checkOutput("blk_done_unexpected", 1, 0);
        else checkOutput("blk_done_time", cyc, done_q.pop_front());
      end
    end
  end

  task automatic pushBlock(input logic inv, input logic [1:0] tq, input logic [1:0] ts);
    int   beats;
    exp_t e;
    case (ts)
      2'b00:   beats = 1;
      2'b01:   beats = 2;
      2'b10:   beats = 8;
      default: beats = 32;
    endcase
    for (int i = 0; i < beats; i++) begin
      e.idx  = i[4:0];
      e.inv  = inv;
      e.tq   = tq;
      e.ts   = ts;
      e.lat  = (ts >= 2'b10) ? LAT_BIG : LAT_SMALL;
      e.last = (i == beats - 1);
      exp_q.push_back(e);
    end
  endtask

  // Issue a command and hold blk_start until it is taken; optionally check
  // that blk_ready stays low and the old config holds while busy.
  task automatic applyStimulus(input logic inv, input logic [1:0] tq, input logic [1:0] ts,
                               input bit gate_chk, input logic [1:0] hold_ts);
    int n = 0;
    pushBlock(inv, tq, ts);
    bus.blk_inverse  = inv;
    bus.blk_tq_sel   = tq;
    bus.blk_transize = ts;
    bus.blk_start    = 1'b1;
    @(negedge clk);
    while (!bus.blk_ready && n < 300) begin
      if (gate_chk) begin
        checkOutput("ready_gate_busy", bus.busy, 1);
        checkOutput("cfg_hold", bus.re_transize, hold_ts);
      end
      @(negedge clk);
      n++;
    end
    checkOutput("accept", bus.blk_ready, 1);
    @(posedge clk);
    #1;
    bus.blk_start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    bit ok;
    ok = 1'b0;
    while (n < budget) begin
      ok = (bus.busy == 1'b0) && (exp_q.size() == 0) && (last_q.size() == 0) && (done_q.size() == 0);
      if (ok) break;
      tick(1);
      n++;
    end
    checkOutput("idle_reached", ok, 1);
  endtask

  task automatic flushModel();
    epoch++;
    exp_q.delete();
    last_q.delete();
    done_q.delete();
  endtask

  task automatic resetDut();
    rst = 1'b1;
    flushModel();
    tick(2);
    @(negedge clk);
    checkOutput("rst_blk_ready", bus.blk_ready, 1);
    checkOutput("rst_src_rdy", bus.src_rdy, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_cfg_idx_done",
                {bus.re_inverse, bus.re_tq_sel, bus.re_transize, bus.beat_idx, bus.blk_done}, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int f0;
    int d0;
    int n;
    bus.blk_start    = 1'b0;
    bus.blk_inverse  = 1'b0;
    bus.blk_tq_sel   = 2'b00;
    bus.blk_transize = 2'b00;
    bus.src_vld      = 1'b0;
    resetDut();
    bus.src_vld = 1'b1;

    $display("[TB] test 1: 32x32 dct with credit echo");
    credit_echo = 1'b1;
    f0 = fire_cnt;
    d0 = done_cnt;
    applyStimulus(1'b0, TQ_LUMA, TS_32, 1'b0, 2'b00);
    waitIdle(600);
    checkOutput("t1_fires", fire_cnt - f0, 32);
    checkOutput("t1_done_cnt", done_cnt - d0, 1);

    $display("[TB] test 2: 4x4 cb");
    tick(8);
    f0 = fire_cnt;
    d0 = done_cnt;
    applyStimulus(1'b0, TQ_CB, TS_4, 1'b0, 2'b00);
    waitIdle(100);
    @(negedge clk);
    checkOutput("t2_fires", fire_cnt - f0, 1);
    checkOutput("t2_done_cnt", done_cnt - d0, 1);
    checkOutput("t2_cfg", {bus.re_tq_sel, bus.re_transize}, 4'b1000);

    $display("[TB] test 3: credit throttling on 16x16");
    resetDut();
    credit_echo = 1'b0;
    f0 = fire_cnt;
    applyStimulus(1'b0, TQ_LUMA, TS_16, 1'b0, 2'b00);
    tick(12);
    @(negedge clk);
    checkOutput("t3_stall_fires", fire_cnt - f0, 4);
    checkOutput("t3_stall_src_rdy", bus.src_rdy, 0);
    tick(1);
    inj_credit = 1'b1;
    tick(1);
    inj_credit = 1'b0;
    tick(5);
    @(negedge clk);
    checkOutput("t3_one_credit", fire_cnt - f0, 5);
    checkOutput("t3_one_src_rdy", bus.src_rdy, 0);
    tick(1);
    inj_credit = 1'b1;
    tick(2);
    inj_credit = 1'b0;
    tick(5);
    @(negedge clk);
    checkOutput("t3_coincident", fire_cnt - f0, 7);
    tick(1);
    inj_credit = 1'b1;
    tick(1);
    inj_credit = 1'b0;
    waitIdle(100);
    checkOutput("t3_total", fire_cnt - f0, 8);
    inj_credit = 1'b1;
    tick(4);
    inj_credit = 1'b0;
    @(negedge clk);
    checkOutput("t3_refill_no_err", bus.err, 0);
    tick(1);
    inj_credit = 1'b1;
    tick(1);
    inj_credit = 1'b0;
    @(negedge clk);
    checkOutput("t3_credit_overflow_err", bus.err, 1);

    $display("[TB] test 4: overlapped 8x8 idct then 32x32");
    resetDut();
    credit_echo = 1'b1;
    fire_cyc.delete();
    d0 = done_cnt;
    applyStimulus(1'b1, TQ_LUMA_ALT, TS_8, 1'b0, 2'b00);
    applyStimulus(1'b1, TQ_LUMA_ALT, TS_8, 1'b0, 2'b00);
    applyStimulus(1'b0, TQ_LUMA, TS_32, 1'b1, TS_8);
    @(negedge clk);
    checkOutput("t4_new_cfg", {bus.re_inverse, bus.re_tq_sel, bus.re_transize}, 5'b00011);
    checkOutput("t4_two_done", done_cnt - d0, 2);
    checkOutput("t4_gap_a", fire_cyc[1] - fire_cyc[0], 1);
    checkOutput("t4_gap_drain", fire_cyc[2] - fire_cyc[1], 2);
    checkOutput("t4_gap_b", fire_cyc[3] - fire_cyc[2], 1);
    waitIdle(600);
    checkOutput("t4_all_done", done_cnt - d0, 3);

    $display("[TB] test 5: stray re_o_vld in IDLE");
    resetDut();
    inj_o = 1'b1;
    tick(1);
    inj_o = 1'b0;
    @(negedge clk);
    checkOutput("t5_err_set", bus.err, 1);
    tick(3);
    @(negedge clk);
    checkOutput("t5_err_sticky", bus.err, 1);
    checkOutput("t5_idle", {bus.busy, bus.src_rdy, bus.blk_ready}, 3'b001);
    d0 = done_cnt;
    tick(1);
    applyStimulus(1'b0, TQ_CR, TS_8, 1'b0, 2'b00);
    waitIdle(100);
    checkOutput("t5_block_after_err", done_cnt - d0, 1);

    $display("[TB] test 6: reset mid-block");
    resetDut();
    f0 = fire_cnt;
    applyStimulus(1'b0, TQ_LUMA, TS_32, 1'b0, 2'b00);
    n = 0;
    while (fire_cnt - f0 < 11 && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput("t6_reached_beat10", (fire_cnt - f0 >= 11), 1);
    rst = 1'b1;
    flushModel();
    #1;
    checkOutput("t6_rst_busy", bus.busy, 0);
    checkOutput("t6_rst_src_rdy", bus.src_rdy, 0);
    checkOutput("t6_rst_blk_ready", bus.blk_ready, 1);
    checkOutput("t6_rst_beat_idx", bus.beat_idx, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    credit_echo = 1'b0;
    f0 = fire_cnt;
    d0 = done_cnt;
    applyStimulus(1'b0, TQ_LUMA, TS_16, 1'b0, 2'b00);
    tick(12);
    @(negedge clk);
    checkOutput("t6_credits_restored", fire_cnt - f0, 4);
    tick(1);
    inj_credit = 1'b1;
    tick(4);
    inj_credit = 1'b0;
    waitIdle(100);
    checkOutput("t6_fresh_fires", fire_cnt - f0, 8);
    checkOutput("t6_fresh_done", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
